// File: rtl/wb_arbiter2_if.sv
// Wishbone bus bundle shared by both arbiter master ports and the downstream slave port.
// dat_w carries master-to-slave write data; dat_r carries slave-to-master read data.
interface wb_arbiter2_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with registered grant and cycle-level lock.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that terminates stalled slave strobes.
module wb_arbiter2 #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter2_if.slave  m0,
    wb_arbiter2_if.slave  m1,
    wb_arbiter2_if.master s,
    output logic [1:0]   gnt_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last;
    logic        w_last_next;

    logic [1:0]  w_cyc;
    logic [1:0]  w_stb;
    logic [1:0]  w_gnt;
    logic [1:0]  w_ack;
    logic        w_stb_raw;
    logic        w_expire;
    logic [31:0] w_rdata;

    assign w_cyc = {m1.cyc, m0.cyc};
    assign w_stb = {m1.stb, m0.stb};
    assign w_gnt = {r_state == ST_GNT1, r_state == ST_GNT0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
        end
    end

    // A tie in IDLE goes to the master that was not granted last; a grant is held
    // for as long as its owner keeps cyc high, then one IDLE cycle re-arbitrates.
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_cyc[0] && (!w_cyc[1] || r_last)) begin
                    w_state_next = ST_GNT0;
                    w_last_next  = 1'b0;
                end else if (w_cyc[1]) begin
                    w_state_next = ST_GNT1;
                    w_last_next  = 1'b1;
                end
            end
            ST_GNT0: begin
                if (!w_cyc[0]) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!w_cyc[1]) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Address/data path follows the last-granted master even in IDLE so it never glitches.
    assign s.we    = r_last ? m1.we    : m0.we;
    assign s.sel   = r_last ? m1.sel   : m0.sel;
    assign s.adr   = r_last ? m1.adr   : m0.adr;
    assign s.dat_w = r_last ? m1.dat_w : m0.dat_w;

    assign w_stb_raw = |(w_gnt & w_stb);
    assign s.cyc     = |(w_gnt & w_cyc);
    assign s.stb     = w_stb_raw & ~w_expire;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign w_ack[gi] = w_gnt[gi] & w_stb[gi] & (s.ack | w_expire);
        end
    endgenerate

    assign w_rdata  = w_expire ? 32'hFFFF_FFFF : s.dat_r;
    assign m0.ack   = w_ack[0];
    assign m1.ack   = w_ack[1];
    assign m0.dat_r = w_rdata;
    assign m1.dat_r = w_rdata;
    assign gnt_o    = w_gnt;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_timeout;

    // A genuine ack on the expiry cycle takes priority over the forced termination.
    assign w_expire = w_stb_raw && !s.ack && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (!w_stb_raw || s.ack || w_expire) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_expire             = 1'b0;
    assign timeout_o            = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: read data and ack routing are checked against a
// scoreboard of expected {master, data} entries; grant/mux/timeout checks are inline.
module tb_wb_arbiter2;

    logic       clk;
    logic       reset;
    logic [1:0] gnt_o;
    logic       timeout_o;

    wb_arbiter2_if m0_if ();
    wb_arbiter2_if m1_if ();
    wb_arbiter2_if s_if ();

    wb_arbiter2 #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .gnt_o    (gnt_o),
        .timeout_o(timeout_o)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic drv(input int idx, input logic cyc, input logic we,
                       input logic [3:0] sel, input logic [29:0] adr, input logic [31:0] dat);
        if (idx == 0) begin
            m0_if.cyc = cyc; m0_if.stb = cyc; m0_if.we = we;
            m0_if.sel = sel; m0_if.adr = adr; m0_if.dat_w = dat;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = cyc; m1_if.we = we;
            m1_if.sel = sel; m1_if.adr = adr; m1_if.dat_w = dat;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge; any ack must match the head of the scoreboard.
    task automatic obs();
        exp_t e;
        int   got_id;
        logic [31:0] got_d;
        @(negedge clk);
        if (m0_if.ack || m1_if.ack) begin
            chk("ack_onehot", 32'(m0_if.ack & m1_if.ack), 32'd0);
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e      = sb_q.pop_front();
                got_id = m1_if.ack ? 1 : 0;
                got_d  = m1_if.ack ? m1_if.dat_r : m0_if.dat_r;
                $display("txn ack master=%0d data=0x%08h expected master=%0d data=0x%08h",
                         got_id, got_d, e.id, e.data);
                chk("ack_master", 32'(got_id), 32'(e.id));
                chk("ack_data", got_d, e.data);
            end
        end
    endtask

    initial begin
        int w;
        reset = 1'b1;
        s_if.ack = 1'b0;
        s_if.dat_r = 32'h0;
        drv(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);

        // reset state
        step(); step(); obs();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_scyc", 32'(s_if.cyc), 32'd0);
        chk("rst_sstb", 32'(s_if.stb), 32'd0);
        chk("rst_ack", 32'({m1_if.ack, m0_if.ack}), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);

        // m0 read, slave acks two clocks after stb
        step(); reset = 1'b0;
        drv(0, 1'b1, 1'b0, 4'hF, 30'h100, 32'h0);
        push_exp(0, 32'hDEAD_BEEF);
        obs();
        chk("t1_idle_gnt", 32'(gnt_o), 32'd0);
        chk("t1_idle_stb", 32'(s_if.stb), 32'd0);
        step(); obs();
        chk("t1_gnt", 32'(gnt_o), 32'd1);
        chk("t1_sstb", 32'(s_if.stb), 32'd1);
        chk("t1_sadr", 32'(s_if.adr), 32'h100);
        chk("t1_swe", 32'(s_if.we), 32'd0);
        step(); obs();
        chk("t1_noack_early", 32'(m0_if.ack), 32'd0);
        step(); s_if.ack = 1'b1; s_if.dat_r = 32'hDEAD_BEEF; obs();
        chk("t1_m0_ack", 32'(m0_if.ack), 32'd1);
        chk("t1_m1_ack", 32'(m1_if.ack), 32'd0);
        step(); s_if.ack = 1'b0; drv(0, 1'b0, 1'b0, 4'hF, 30'h100, 32'h0); obs();
        chk("t1_hold_gnt", 32'(gnt_o), 32'd1);
        chk("t1_drop_scyc", 32'(s_if.cyc), 32'd0);
        step(); obs();
        chk("t1_back_idle", 32'(gnt_o), 32'd0);

        // tie after reset goes to m0, then strict alternation
        reset = 1'b1; step(); reset = 1'b0; step();
        drv(0, 1'b1, 1'b0, 4'hF, 30'h40, 32'h0);
        drv(1, 1'b1, 1'b0, 4'hF, 30'h41, 32'h0);
        for (int k = 0; k < 8; k++) begin
            w = k % 2;
            push_exp(w, 32'hA000_0000 + 32'(k));
            obs();
            chk("t2_idle_gnt", 32'(gnt_o), 32'd0);
            step(); s_if.ack = 1'b1; s_if.dat_r = 32'hA000_0000 + 32'(k); obs();
            chk("t2_gnt", 32'(gnt_o), (w == 1) ? 32'd2 : 32'd1);
            step(); s_if.ack = 1'b0; drv(w, 1'b0, 1'b0, 4'hF, 30'h40 + 30'(w), 32'h0); obs();
            chk("t2_release_scyc", 32'(s_if.cyc), 32'd0);
            step(); drv(w, 1'b1, 1'b0, 4'hF, 30'h40 + 30'(w), 32'h0);
        end
        drv(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        obs(); step();

        // m1 write; m0 requests mid-cycle and must wait for release
        drv(1, 1'b1, 1'b1, 4'b0011, 30'h2000, 32'h1234);
        obs();
        chk("t3_idle_gnt", 32'(gnt_o), 32'd0);
        step(); drv(0, 1'b1, 1'b0, 4'hF, 30'h300, 32'h0); obs();
        chk("t3_gnt", 32'(gnt_o), 32'd2);
        chk("t3_swe", 32'(s_if.we), 32'd1);
        chk("t3_ssel", 32'(s_if.sel), 32'h3);
        chk("t3_sadr", 32'(s_if.adr), 32'h2000);
        chk("t3_sdat", s_if.dat_w, 32'h1234);
        step(); s_if.ack = 1'b1; s_if.dat_r = 32'h0; push_exp(1, 32'h0); obs();
        chk("t3_m0_waits", 32'(m0_if.ack), 32'd0);
        step(); s_if.ack = 1'b0; drv(1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0); obs();
        chk("t3_hold_gnt", 32'(gnt_o), 32'd2);
        step(); obs();
        chk("t3_dead_cycle", 32'(gnt_o), 32'd0);
        chk("t3_dead_stb", 32'(s_if.stb), 32'd0);
        step(); obs();
        chk("t3_m0_gnt", 32'(gnt_o), 32'd1);
        chk("t3_m0_adr", 32'(s_if.adr), 32'h300);
        push_exp(0, 32'h5555_AAAA);
        step(); s_if.ack = 1'b1; s_if.dat_r = 32'h5555_AAAA; obs();
        step(); s_if.ack = 1'b0; drv(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0); obs();
        step(); obs();
        chk("t3_end_idle", 32'(gnt_o), 32'd0);

        // m0 abort before ack; late slave ack must be dropped
        drv(0, 1'b1, 1'b0, 4'hF, 30'h400, 32'h0); obs();
        step(); obs();
        chk("t6_gnt", 32'(gnt_o), 32'd1);
        chk("t6_sstb", 32'(s_if.stb), 32'd1);
        step(); drv(0, 1'b0, 1'b0, 4'hF, 30'h400, 32'h0); s_if.ack = 1'b1; obs();
        chk("t6_abort_m0_ack", 32'(m0_if.ack), 32'd0);
        step(); obs();
        chk("t6_late_m0_ack", 32'(m0_if.ack), 32'd0);
        chk("t6_late_m1_ack", 32'(m1_if.ack), 32'd0);
        chk("t6_idle", 32'(gnt_o), 32'd0);
        step(); s_if.ack = 1'b0;

        // reset while GNT1 with stb high
        drv(1, 1'b1, 1'b0, 4'hF, 30'h500, 32'h0); obs();
        step(); obs();
        chk("t4_gnt1", 32'(gnt_o), 32'd2);
        chk("t4_sstb", 32'(s_if.stb), 32'd1);
        #1; reset = 1'b1; s_if.ack = 1'b1;
        #1;
        chk("t4_async_scyc", 32'(s_if.cyc), 32'd0);
        chk("t4_async_sstb", 32'(s_if.stb), 32'd0);
        chk("t4_async_gnt", 32'(gnt_o), 32'd0);
        chk("t4_async_m1ack", 32'(m1_if.ack), 32'd0);
        drv(0, 1'b1, 1'b0, 4'hF, 30'h501, 32'h0);
        step(); reset = 1'b0; s_if.ack = 1'b0; obs();
        chk("t4_idle", 32'(gnt_o), 32'd0);
        step(); obs();
        chk("t4_tie_m0", 32'(gnt_o), 32'd1);
        push_exp(0, 32'h0BAD_F00D);
        step(); s_if.ack = 1'b1; s_if.dat_r = 32'h0BAD_F00D; obs();
        step(); s_if.ack = 1'b0;
        drv(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        obs(); step(); obs(); step();

`ifdef WB_ARB_TIMEOUT_EN
        // slave never acks: forced termination on the 16th strobe cycle
        s_if.dat_r = 32'h1234_5678;
        push_exp(0, 32'hFFFF_FFFF);
        drv(0, 1'b1, 1'b0, 4'hF, 30'h600, 32'h0); obs();
        for (int i = 1; i <= 16; i++) begin
            step(); obs();
            chk("t5_ack", 32'(m0_if.ack), (i == 16) ? 32'd1 : 32'd0);
            chk("t5_sstb", 32'(s_if.stb), (i == 16) ? 32'd0 : 32'd1);
            chk("t5_to_early", 32'(timeout_o), 32'd0);
        end
        step(); drv(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0); obs();
        chk("t5_to_pulse", 32'(timeout_o), 32'd1);
        chk("t5_no_reack", 32'(m0_if.ack), 32'd0);
        step(); obs();
        chk("t5_to_single", 32'(timeout_o), 32'd0);
        step();

        // real ack exactly on the expiry cycle wins
        push_exp(0, 32'h600D_600D);
        drv(0, 1'b1, 1'b0, 4'hF, 30'h601, 32'h0); obs();
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 16) begin
                s_if.ack = 1'b1; s_if.dat_r = 32'h600D_600D;
            end
            obs();
            chk("t5b_ack", 32'(m0_if.ack), (i == 16) ? 32'd1 : 32'd0);
            chk("t5b_to", 32'(timeout_o), 32'd0);
        end
        step(); s_if.ack = 1'b0; drv(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0); obs();
        chk("t5b_no_pulse", 32'(timeout_o), 32'd0);
        step(); obs();
        chk("t5b_no_pulse2", 32'(timeout_o), 32'd0);
`else
        // without the watchdog a stalled slave holds the bus indefinitely
        s_if.dat_r = 32'h1234_5678;
        drv(0, 1'b1, 1'b0, 4'hF, 30'h600, 32'h0); obs();
        for (int i = 1; i <= 20; i++) begin
            step(); obs();
            chk("t5_stall_ack", 32'(m0_if.ack), 32'd0);
            chk("t5_stall_stb", 32'(s_if.stb), 32'd1);
            chk("t5_stall_to", 32'(timeout_o), 32'd0);
        end
        step(); drv(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0); obs();
`endif

        step(); obs();
        chk("end_idle", 32'(gnt_o), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
